// File: rtl/arbl2_rr_pkg.sv
// Shared L2/directory memory-channel payload types and buffer depth used by the
// arbl2_rr slice; every module imports these rather than declaring its own copy.
package arbl2_rr_pkg;

  localparam int BUF_DEPTH = 2;
  localparam int L2ID_W    = 6;

  typedef struct packed {
    logic [L2ID_W-1:0] l2id;
    logic [2:0]        cmd;
    logic [31:0]       paddr;
  } I_l2todr_req_type;

  typedef struct packed {
    logic [L2ID_W-1:0] l2id;
    logic [3:0]        snack;
    logic [31:0]       paddr;
  } I_drtol2_snack_type;

endpackage

// File: rtl/arbl2_rr_if.sv
// Bundle of every valid/retry channel around the L2 round-robin arbiter:
// per-pipe requests in, merged request out, directory snacks in, per-pipe snacks out.
interface arbl2_rr_if
  import arbl2_rr_pkg::*;
#(
  parameter int NPORTS = 4
);
  logic [NPORTS-1:0]  l2d_todr_req_valid;
  logic [NPORTS-1:0]  l2d_todr_req_retry;
  I_l2todr_req_type   l2d_todr_req [NPORTS];

  logic               l2todr_req_valid;
  logic               l2todr_req_retry;
  I_l2todr_req_type   l2todr_req;

  logic               drtol2_snack_valid;
  logic               drtol2_snack_retry;
  I_drtol2_snack_type drtol2_snack;

  logic [NPORTS-1:0]  drtol2d_snack_valid;
  logic [NPORTS-1:0]  drtol2d_snack_retry;
  I_drtol2_snack_type drtol2d_snack [NPORTS];

  logic [7:0]         snack_drop_cnt;

  modport slave (
    input  l2d_todr_req_valid, l2d_todr_req,
    output l2d_todr_req_retry,
    output l2todr_req_valid, l2todr_req,
    input  l2todr_req_retry,
    input  drtol2_snack_valid, drtol2_snack,
    output drtol2_snack_retry,
    output drtol2d_snack_valid, drtol2d_snack,
    input  drtol2d_snack_retry,
    output snack_drop_cnt
  );

  modport master (
    output l2d_todr_req_valid, l2d_todr_req,
    input  l2d_todr_req_retry,
    input  l2todr_req_valid, l2todr_req,
    output l2todr_req_retry,
    output drtol2_snack_valid, drtol2_snack,
    input  drtol2_snack_retry,
    input  drtol2d_snack_valid, drtol2d_snack,
    output drtol2d_snack_retry,
    input  snack_drop_cnt
  );

endinterface

// File: rtl/arbl2_rr_buf.sv
// Two-entry valid/retry elastic buffer. Output valid comes straight from the
// occupancy register, so downstream retry never reaches out_valid combinationally.
module arbl2_rr_buf
  import arbl2_rr_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_retry,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_retry,
  output logic [DATA_W-1:0] out_data
);

  localparam int AW = $clog2(BUF_DEPTH);
  localparam int CW = $clog2(BUF_DEPTH + 1);

  logic [DATA_W-1:0] mem_p1 [BUF_DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic [CW-1:0]     cnt;
  logic              push;
  logic              pop;

  // A pop in the same cycle frees a slot, so a full buffer still takes a push.
  assign out_valid = !reset && (cnt != '0);
  assign pop       = out_valid && !out_retry;
  assign in_retry  = !reset && (cnt == CW'(BUF_DEPTH)) && !pop;
  assign push      = !reset && in_valid && !in_retry;
  assign out_data  = mem_p1[rd_ptr];

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   cnt <= cnt + CW'(1);
        2'b01:   cnt <= cnt - CW'(1);
        default: cnt <= cnt;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_p1[wr_ptr] <= in_data;
  end

endmodule

// File: rtl/arbl2_rr.sv
// Round-robin merge of NPORTS L2 request pipes onto one directory channel, and
// l2id-based fan-out of directory snacks back to the pipes with per-pipe buffering.
module arbl2_rr
  import arbl2_rr_pkg::*;
#(
  parameter int NPORTS = 4,
  parameter int IDW    = 6
) (
  input  logic        clk,
  input  logic        reset,
  arbl2_rr_if.slave   bus
);

  localparam int PW      = (NPORTS > 1) ? $clog2(NPORTS) : 1;
  localparam int REQ_W   = $bits(I_l2todr_req_type);
  localparam int SNACK_W = $bits(I_drtol2_snack_type);

  logic [PW-1:0]      rr_ptr;
  logic [PW-1:0]      grant;
  logic [PW:0]        idx_sum;
  logic               any_valid;
  logic               req_full;
  logic [NPORTS-1:0]  req_retry;
  I_l2todr_req_type   grant_req;
  logic [REQ_W-1:0]   req_out_data;

  // Request side: pick the first valid pipe at or after rr_ptr.
  always_comb begin
    grant     = '0;
    any_valid = 1'b0;
    idx_sum   = '0;
    for (int i = 0; i < NPORTS; i++) begin
      idx_sum = {1'b0, rr_ptr} + (PW+1)'(i);
      if (idx_sum >= (PW+1)'(NPORTS)) idx_sum = idx_sum - (PW+1)'(NPORTS);
      if (!any_valid && bus.l2d_todr_req_valid[idx_sum[PW-1:0]]) begin
        any_valid = 1'b1;
        grant     = idx_sum[PW-1:0];
      end
    end
  end

  assign grant_req = bus.l2d_todr_req[grant];

  always_comb begin
    req_retry = '0;
    for (int p = 0; p < NPORTS; p++) begin
      req_retry[p] = !reset && bus.l2d_todr_req_valid[p] &&
                     ((grant != PW'(p)) || req_full);
    end
  end

  assign bus.l2d_todr_req_retry = req_retry;

  always_ff @(posedge clk) begin
    if (reset) begin
      rr_ptr <= '0;
    end else if (any_valid && !req_full) begin
      rr_ptr <= (grant == PW'(NPORTS-1)) ? '0 : grant + PW'(1);
    end
  end

  arbl2_rr_buf #(.DATA_W(REQ_W)) u_req_buf (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (any_valid),
    .in_retry  (req_full),
    .in_data   (grant_req),
    .out_valid (bus.l2todr_req_valid),
    .out_retry (bus.l2todr_req_retry),
    .out_data  (req_out_data)
  );

  assign bus.l2todr_req = req_out_data;

  // Snack side: IDW must not exceed the l2id field width of the snack payload.
  logic [IDW-1:0]     snack_port;
  logic               in_range;
  logic [NPORTS-1:0]  snk_in_valid;
  logic [NPORTS-1:0]  snk_full;
  logic [NPORTS-1:0]  snk_out_valid;
  logic [SNACK_W-1:0] snk_out_data [NPORTS];
  logic [7:0]         drop_cnt;

  assign snack_port = bus.drtol2_snack.l2id[IDW-1:0];
  assign in_range   = (int'(snack_port) < NPORTS);

  for (genvar i = 0; i < NPORTS; i++) begin : g_snack
    assign snk_in_valid[i] = bus.drtol2_snack_valid && in_range &&
                             (int'(snack_port) == i);

    arbl2_rr_buf #(.DATA_W(SNACK_W)) u_snack_buf (
      .clk       (clk),
      .reset     (reset),
      .in_valid  (snk_in_valid[i]),
      .in_retry  (snk_full[i]),
      .in_data   (bus.drtol2_snack),
      .out_valid (snk_out_valid[i]),
      .out_retry (bus.drtol2d_snack_retry[i]),
      .out_data  (snk_out_data[i])
    );

    assign bus.drtol2d_snack[i] = snk_out_data[i];
  end

  assign bus.drtol2d_snack_valid = snk_out_valid;
  assign bus.drtol2_snack_retry  = |(snk_in_valid & snk_full);

  // Out-of-range snacks are swallowed without retry and only counted.
  always_ff @(posedge clk) begin
    if (reset) begin
      drop_cnt <= '0;
    end else if (bus.drtol2_snack_valid && !in_range && (drop_cnt != 8'hFF)) begin
      drop_cnt <= drop_cnt + 8'd1;
    end
  end

  assign bus.snack_drop_cnt = drop_cnt;

endmodule

// File: tb/tb_arbl2_rr.sv
// Directed bench for arbl2_rr: inputs change on the falling edge and every
// check is taken 1ns later, well away from the rising edge.
module tb_arbl2_rr;
  import arbl2_rr_pkg::*;

  localparam int NP = 4;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   nvec = 0;
  int   nerr = 0;

  arbl2_rr_if #(.NPORTS(NP)) bus ();

  arbl2_rr #(.NPORTS(NP), .IDW(6)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Retry scenario: per-step input valids, downstream retry, and expected results.
  logic [3:0] t_vin [11] = '{4'b1010, 4'b1010, 4'b1010, 4'b1010, 4'b1010, 4'b1010,
                             4'b1010, 4'b1010, 4'b0000, 4'b0000, 4'b0000};
  logic       t_dr  [11] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0,
                             1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
  logic [3:0] t_ret [11] = '{4'b1000, 4'b0010, 4'b1010, 4'b1010, 4'b1010, 4'b1000,
                             4'b0010, 4'b1000, 4'b0000, 4'b0000, 4'b0000};
  logic       t_ov  [11] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1,
                             1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
  int         t_id  [11] = '{0, 1, 1, 1, 1, 1, 3, 1, 3, 1, 0};

  function automatic I_l2todr_req_type mkreq(input int p);
    I_l2todr_req_type r;
    r.l2id  = 6'(p);
    r.cmd   = 3'(p + 1);
    r.paddr = 32'h1000_0000 + 32'(p) * 32'h40;
    return r;
  endfunction

  function automatic I_drtol2_snack_type mksnk(input int id, input int n);
    I_drtol2_snack_type s;
    s.l2id  = 6'(id);
    s.snack = 4'(n);
    s.paddr = 32'hA000_0000 + 32'(n);
    return s;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nvec++;
    assert (obs === exp)
    else begin
      nerr++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic drive_snack(input logic v, input int id, input int n);
    bus.drtol2_snack_valid = v;
    bus.drtol2_snack       = mksnk(id, n);
  endtask

  initial begin
    logic [3:0] e_ret;
    bus.l2d_todr_req_valid  = '0;
    bus.l2todr_req_retry    = 1'b0;
    bus.drtol2d_snack_retry = '0;
    for (int p = 0; p < NP; p++) bus.l2d_todr_req[p] = mkreq(p);
    drive_snack(1'b0, 0, 0);

    // Reset state, with traffic offered on every input.
    step();
    bus.l2d_todr_req_valid = 4'hF;
    drive_snack(1'b1, 1, 0);
    settle();
    chk("rst_req_retry",   64'(bus.l2d_todr_req_retry),  64'h0);
    chk("rst_req_valid",   64'(bus.l2todr_req_valid),    64'h0);
    chk("rst_snack_retry", 64'(bus.drtol2_snack_retry),  64'h0);
    chk("rst_snack_valid", 64'(bus.drtol2d_snack_valid), 64'h0);
    chk("rst_drop_cnt",    64'(bus.snack_drop_cnt),      64'h0);

    // All pipes valid, no downstream retry: grants rotate 0,1,2,3,...
    for (int k = 0; k < 8; k++) begin
      step();
      if (k == 0) begin
        reset = 1'b0;
        drive_snack(1'b0, 0, 0);
      end
      settle();
      e_ret = 4'hF & ~(4'h1 << (k % 4));
      chk("rr_retry",  64'(bus.l2d_todr_req_retry), 64'(e_ret));
      chk("rr_ovalid", 64'(bus.l2todr_req_valid),   64'(k >= 1));
      if (k >= 1) chk("rr_odata", 64'(bus.l2todr_req), 64'(mkreq((k - 1) % 4)));
    end
    step();
    bus.l2d_todr_req_valid = '0;
    settle();
    chk("rr_tail_valid", 64'(bus.l2todr_req_valid), 64'h1);
    chk("rr_tail_data",  64'(bus.l2todr_req),       64'(mkreq(3)));
    step();
    settle();
    chk("rr_empty", 64'(bus.l2todr_req_valid), 64'h0);

    // Ports 1 and 3 against a 5-cycle downstream stall, then release.
    for (int s = 0; s < 11; s++) begin
      step();
      bus.l2d_todr_req_valid = t_vin[s];
      bus.l2todr_req_retry   = t_dr[s];
      settle();
      chk("stall_retry",  64'(bus.l2d_todr_req_retry), 64'(t_ret[s]));
      chk("stall_ovalid", 64'(bus.l2todr_req_valid),   64'(t_ov[s]));
      if (t_ov[s]) chk("stall_odata", 64'(bus.l2todr_req), 64'(mkreq(t_id[s])));
    end

    // Snacks to l2id 2, 0 and out-of-range 7.
    step();
    drive_snack(1'b1, 2, 1);
    settle();
    chk("snk_retry0", 64'(bus.drtol2_snack_retry),  64'h0);
    chk("snk_valid0", 64'(bus.drtol2d_snack_valid), 64'h0);
    step();
    drive_snack(1'b1, 0, 2);
    settle();
    chk("snk_retry1", 64'(bus.drtol2_snack_retry),  64'h0);
    chk("snk_valid1", 64'(bus.drtol2d_snack_valid), 64'h4);
    chk("snk_data2",  64'(bus.drtol2d_snack[2]),    64'(mksnk(2, 1)));
    step();
    drive_snack(1'b1, 7, 3);
    settle();
    chk("snk_drop_retry", 64'(bus.drtol2_snack_retry),  64'h0);
    chk("snk_valid2",     64'(bus.drtol2d_snack_valid), 64'h1);
    chk("snk_data0",      64'(bus.drtol2d_snack[0]),    64'(mksnk(0, 2)));
    step();
    drive_snack(1'b0, 0, 0);
    settle();
    chk("snk_valid3", 64'(bus.drtol2d_snack_valid), 64'h0);
    chk("snk_drop1",  64'(bus.snack_drop_cnt),      64'h1);

    // Port 1 stalled: third snack retried, port 0 snack follows the release.
    step();
    bus.drtol2d_snack_retry = 4'b0010;
    drive_snack(1'b1, 1, 10);
    settle();
    chk("hol_retry_a", 64'(bus.drtol2_snack_retry), 64'h0);
    step();
    drive_snack(1'b1, 1, 11);
    settle();
    chk("hol_retry_b", 64'(bus.drtol2_snack_retry),  64'h0);
    chk("hol_valid_a", 64'(bus.drtol2d_snack_valid), 64'h2);
    chk("hol_data_a",  64'(bus.drtol2d_snack[1]),    64'(mksnk(1, 10)));
    step();
    drive_snack(1'b1, 1, 12);
    settle();
    chk("hol_retry_c", 64'(bus.drtol2_snack_retry), 64'h1);
    step();
    settle();
    chk("hol_retry_c2", 64'(bus.drtol2_snack_retry), 64'h1);
    chk("hol_hold_a",   64'(bus.drtol2d_snack[1]),   64'(mksnk(1, 10)));
    step();
    bus.drtol2d_snack_retry = '0;
    settle();
    chk("hol_rel_retry", 64'(bus.drtol2_snack_retry),  64'h0);
    chk("hol_rel_valid", 64'(bus.drtol2d_snack_valid), 64'h2);
    chk("hol_rel_a",     64'(bus.drtol2d_snack[1]),    64'(mksnk(1, 10)));
    step();
    drive_snack(1'b1, 0, 13);
    settle();
    chk("hol_retry_d", 64'(bus.drtol2_snack_retry), 64'h0);
    chk("hol_data_b",  64'(bus.drtol2d_snack[1]),   64'(mksnk(1, 11)));
    step();
    drive_snack(1'b0, 0, 0);
    settle();
    chk("hol_valid_cd", 64'(bus.drtol2d_snack_valid), 64'h3);
    chk("hol_data_c",   64'(bus.drtol2d_snack[1]),    64'(mksnk(1, 12)));
    chk("hol_data_d",   64'(bus.drtol2d_snack[0]),    64'(mksnk(0, 13)));
    step();
    settle();
    chk("hol_empty", 64'(bus.drtol2d_snack_valid), 64'h0);
    chk("hol_drop",  64'(bus.snack_drop_cnt),      64'h1);

    // Fill the request buffer and snack port 0, then reset.
    step();
    bus.l2d_todr_req_valid  = 4'b0001;
    bus.l2todr_req_retry    = 1'b1;
    bus.drtol2d_snack_retry = 4'b0001;
    drive_snack(1'b1, 0, 20);
    settle();
    chk("fill_req_retry0", 64'(bus.l2d_todr_req_retry), 64'h0);
    step();
    drive_snack(1'b1, 0, 21);
    settle();
    chk("fill_req_retry1", 64'(bus.l2d_todr_req_retry), 64'h0);
    chk("fill_snk_retry1", 64'(bus.drtol2_snack_retry), 64'h0);
    step();
    settle();
    chk("full_req_retry", 64'(bus.l2d_todr_req_retry),  64'h1);
    chk("full_req_valid", 64'(bus.l2todr_req_valid),    64'h1);
    chk("full_snk_retry", 64'(bus.drtol2_snack_retry),  64'h1);
    chk("full_snk_valid", 64'(bus.drtol2d_snack_valid), 64'h1);
    reset = 1'b1;
    settle();
    chk("inrst_req_valid", 64'(bus.l2todr_req_valid),    64'h0);
    chk("inrst_snk_valid", 64'(bus.drtol2d_snack_valid), 64'h0);
    chk("inrst_req_retry", 64'(bus.l2d_todr_req_retry),  64'h0);
    chk("inrst_snk_retry", 64'(bus.drtol2_snack_retry),  64'h0);
    step();
    reset = 1'b0;
    bus.l2d_todr_req_valid  = 4'hF;
    bus.l2todr_req_retry    = 1'b0;
    bus.drtol2d_snack_retry = '0;
    drive_snack(1'b0, 0, 0);
    settle();
    chk("post_req_valid", 64'(bus.l2todr_req_valid),    64'h0);
    chk("post_snk_valid", 64'(bus.drtol2d_snack_valid), 64'h0);
    chk("post_drop_cnt",  64'(bus.snack_drop_cnt),      64'h0);
    chk("post_rr_ptr",    64'(bus.l2d_todr_req_retry),  64'hE);
    step();
    bus.l2d_todr_req_valid = '0;
    settle();
    chk("post_first_valid", 64'(bus.l2todr_req_valid), 64'h1);
    chk("post_first_data",  64'(bus.l2todr_req),       64'(mkreq(0)));
    step();
    settle();
    chk("post_empty", 64'(bus.l2todr_req_valid), 64'h0);

    // 300 snacks with l2id == NPORTS: drop counter saturates at 255.
    step();
    drive_snack(1'b1, 4, 30);
    settle();
    chk("sat_retry", 64'(bus.drtol2_snack_retry), 64'h0);
    for (int i = 1; i <= 300; i++) begin
      step();
      settle();
      if (i == 254) chk("sat_254", 64'(bus.snack_drop_cnt), 64'd254);
      if (i == 255) chk("sat_255", 64'(bus.snack_drop_cnt), 64'd255);
    end
    drive_snack(1'b0, 0, 0);
    chk("sat_300",   64'(bus.snack_drop_cnt),      64'd255);
    chk("sat_noout", 64'(bus.drtol2d_snack_valid), 64'h0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
